// File: rtl/trace_capture_buffer.sv
// Trace record capture FIFO with a req/gnt/rvalid drain port and a saturating drop counter.
// Optional feature: define TRACE_CAPTURE_TIMESTAMP_EN to prepend a 32-bit cycle timestamp to each entry.
module trace_capture_buffer #(
    parameter int TRACE_WIDTH = 128,
    parameter int DEPTH       = 16,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int ENTRY_WIDTH = TRACE_WIDTH + 32
`else
    localparam int ENTRY_WIDTH = TRACE_WIDTH
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   trace_valid_i,
    input  logic [TRACE_WIDTH-1:0] trace_data_i,
    input  logic                   capture_en_i,
    input  logic                   clear_i,
    input  logic                   rd_req_i,
    output logic                   rd_gnt_o,
    output logic                   rd_rvalid_o,
    output logic [ENTRY_WIDTH-1:0] rd_rdata_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_count_o
);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic                   rvalid_q;
    logic [ENTRY_WIDTH-1:0] rdata_q;
    logic [ENTRY_WIDTH-1:0] entry;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = rd_req_i && (count_q != '0) && !clear_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the record.
    assign push = trace_valid_i && capture_en_i && (!full || pop) && !clear_i;
    assign drop = trace_valid_i && capture_en_i && full && !pop && !clear_i;

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;

    assign ts_d  = clear_i ? 32'd0 : ts_q + 32'd1;
    assign entry = {ts_q, trace_data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q <= 32'd0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign entry = trace_data_i;
`endif

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            rvalid_q   <= pop;
            if (pop) begin
                rdata_q <= mem[rptr_q];
            end
        end
    end

    assign rd_gnt_o     = pop;
    assign rd_rvalid_o  = rvalid_q;
    assign rd_rdata_o   = rdata_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Receiving end of the trace unit's output stream: captures each trace record presented with the trace-ready strobe into an on-chip FIFO and drains it through a req/gnt/rvalid read port of the same shape as the core's memory interfaces. It sits beside the trace unit in the system and is read by a debug host or testbench monitor. Records arriving when the FIFO is full are dropped and counted, never stalling the trace source.

## Interface
Parameters:
- TRACE_WIDTH, 128, width of one flattened trace record
- DEPTH, 16, FIFO entries; power of two, ≥2
- ENTRY_WIDTH, derived, TRACE_WIDTH (+32 with timestamp feature)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- trace_valid_i  in  1  record strobe (driven by trace unit's trace_ready)
- trace_data_i  in  TRACE_WIDTH  flattened trace record
- capture_en_i  in  1  0 = ignore all incoming records
- clear_i  in  1  synchronous flush
- rd_req_i  in  1  read request
- rd_gnt_o  out  1  read grant, combinational
- rd_rvalid_o  out  1  read data valid, one cycle after grant
- rd_rdata_o  out  ENTRY_WIDTH  read data
- count_o  out  $clog2(DEPTH)+1  entries held
- full_o  out  1  count_o == DEPTH
- overflow_o  out  1  sticky: at least one record dropped
- drop_count_o  out  16  dropped records, saturating

## Operation
- Storage: circular buffer, write/read pointers $clog2(DEPTH) bits, wrap naturally; count register tracks occupancy.
- Push: trace_valid_i && capture_en_i && (!full_o || pop this cycle). Entry written at wptr, wptr++.
- Drop: trace_valid_i && capture_en_i && full_o && no pop → record discarded, overflow_o ← 1, drop_count_o++ saturating at 16'hFFFF.
- Grant: rd_gnt_o = rd_req_i && count_o != 0 && !clear_i. Grant pops entry at rptr, rptr++.
- Response: registered; rd_rvalid_o = 1 in cycle after grant, rd_rdata_o = popped entry. rd_rdata_o holds last value when rd_rvalid_o = 0.
- Count: +1 on push-only, −1 on pop-only, unchanged on push+pop.
- Empty + same-cycle push and req: no grant; entry grantable next cycle (no bypass).
- Full + same-cycle push and grant: both occur, count stays DEPTH, no drop.
- clear_i: pointers, count, overflow_o, drop_count_o → 0 next edge; overrides push, pop and drop that cycle. An rd_rvalid_o already scheduled from the previous cycle's grant still completes.
- capture_en_i = 0: incoming records neither stored nor counted as drops.

## Timing
- Reset (async, rst_i = 1): rd_gnt_o 0 (count 0), rd_rvalid_o 0, rd_rdata_o 0, count_o 0, full_o 0, overflow_o 0, drop_count_o 0, pointers 0, timestamp 0.
- Grant-to-data latency: 1 cycle. Back-to-back grants yield back-to-back rvalid, one entry per cycle.
- Push-to-grantable latency: 1 cycle.
- count_o, full_o, overflow_o, drop_count_o are registered; they update the edge after the causing event.
- Reset mid-read: pending rvalid is cancelled; rd_rvalid_o is 0 immediately.

## Configuration
- Macro: TRACE_CAPTURE_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter, reset to 0 by rst_i or clear_i, wraps at 2^32. Each stored entry is {timestamp at push cycle, trace_data_i}. ENTRY_WIDTH = TRACE_WIDTH+32.
- Undefined: no counter; entry = trace_data_i; ENTRY_WIDTH = TRACE_WIDTH.

## Test plan
- Reset, then 3 strobes with data 1, 2, 3 on consecutive cycles, then rd_req_i held 3 cycles → grants in 3 consecutive cycles, rvalid data 1, 2, 3 on the following cycles, count_o returns to 0.
- DEPTH=16, 18 strobes without reads → full_o = 1 after the 16th, overflow_o = 1, drop_count_o = 2; reads return records 1..16 only.
- FIFO full, strobe and rd_req_i in same cycle → one grant, no drop, count_o stays 16, the new record is read last.
- Empty FIFO, strobe and rd_req_i in same cycle → rd_gnt_o = 0 that cycle, = 1 next cycle, rvalid data equals the strobed record.
- After an overflow, pulse clear_i with rd_req_i high → no grant, count_o 0, overflow_o 0, drop_count_o 0; strobes with capture_en_i = 0 leave count_o at 0.
- TRACE_CAPTURE_TIMESTAMP_EN defined, release reset at cycle 0, strobes at cycles 5 and 9 → upper 32 bits of read data are 5 and 9.
